// File: rtl/rv_inst_encoder.sv
// RV32I field-bundle to instruction-word encoder with per-format immediate range checks.
// Optional macro RV_ENC_LI_EXPAND_EN splits an out-of-range "li" (ADDI rd,x0,imm) into LUI+ADDI.
module rv_inst_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_func3,
    input  logic [6:0]  in_func7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic        out_first
);

    typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtBad} fmt_e;
    typedef enum logic [0:0] {StIdle, StExp2} state_e;

    fmt_e        fmt;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        shamt_ok;
    logic        is_shift;
    logic        enc_expand;
    logic        enc_err;
    logic [31:0] enc_word;
    logic [31:0] addi_word;

    state_e      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        out_err_q, out_err_d;
    logic        out_first_q, out_first_d;
    logic [31:0] pending_q, pending_d;
    logic        accept;
    logic        consume;

    always_comb begin
        case (in_opcode)
            5'b01100:                     fmt = FmtR;
            5'b00000, 5'b00100, 5'b11001: fmt = FmtI;
            5'b01000:                     fmt = FmtS;
            5'b11000:                     fmt = FmtB;
            5'b01101, 5'b00101:           fmt = FmtU;
            5'b11011:                     fmt = FmtJ;
            default:                      fmt = FmtBad;
        endcase
    end

    // A signed N-bit value has all bits from N-1 upward equal.
    assign fits12   = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits13   = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fits21   = (&in_imm[31:20]) | ~(|in_imm[31:20]);
    assign shamt_ok = ~(|in_imm[31:5]);
    assign is_shift = (in_opcode == 5'b00100) && ((in_func3 == 3'b001) || (in_func3 == 3'b101));

    assign addi_word = {in_imm[11:0], in_rd, 3'b000, in_rd, 7'b0010011};

`ifdef RV_ENC_LI_EXPAND_EN
    logic [31:0] lui_hi;
    assign lui_hi     = in_imm + 32'h0000_0800;
    assign enc_expand = (in_opcode == 5'b00100) && (in_func3 == 3'b000) && (in_rs1 == 5'd0)
                        && !fits12;
`else
    assign enc_expand = 1'b0;
`endif

    always_comb begin
        enc_word = {25'd0, in_opcode, 2'b11};
        enc_err  = 1'b0;
        case (fmt)
            FmtR: begin
                enc_word[11:7]  = in_rd;
                enc_word[14:12] = in_func3;
                enc_word[19:15] = in_rs1;
                enc_word[24:20] = in_rs2;
                enc_word[31:25] = in_func7;
            end
            FmtI: begin
                enc_word[11:7]  = in_rd;
                enc_word[14:12] = in_func3;
                enc_word[19:15] = in_rs1;
                if (is_shift) begin
                    enc_word[24:20] = in_imm[4:0];
                    enc_word[31:25] = in_func7;
                    enc_err         = !shamt_ok;
                end else begin
                    enc_word[31:20] = in_imm[11:0];
                    enc_err         = !fits12 && !enc_expand;
                end
            end
            FmtS: begin
                enc_word[11:7]  = in_imm[4:0];
                enc_word[14:12] = in_func3;
                enc_word[19:15] = in_rs1;
                enc_word[24:20] = in_rs2;
                enc_word[31:25] = in_imm[11:5];
                enc_err         = !fits12;
            end
            FmtB: begin
                enc_word[7]     = in_imm[11];
                enc_word[11:8]  = in_imm[4:1];
                enc_word[14:12] = in_func3;
                enc_word[19:15] = in_rs1;
                enc_word[24:20] = in_rs2;
                enc_word[30:25] = in_imm[10:5];
                enc_word[31]    = in_imm[12];
                enc_err         = !fits13 || in_imm[0];
            end
            FmtU: begin
                enc_word[11:7]  = in_rd;
                enc_word[31:12] = in_imm[31:12];
                enc_err         = |in_imm[11:0];
            end
            FmtJ: begin
                enc_word[11:7]  = in_rd;
                enc_word[19:12] = in_imm[19:12];
                enc_word[20]    = in_imm[11];
                enc_word[30:21] = in_imm[10:1];
                enc_word[31]    = in_imm[20];
                enc_err         = !fits21 || in_imm[0];
            end
            default: enc_err = 1'b1;
        endcase
`ifdef RV_ENC_LI_EXPAND_EN
        if (enc_expand) begin
            enc_word = {lui_hi[31:12], in_rd, 7'b0110111};
        end
`endif
        if (enc_err) begin
            enc_word = 32'h0;
        end
    end

    assign consume  = out_valid_q && out_ready;
    assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_err_d   = out_err_q;
        out_first_d = out_first_q;
        pending_d   = pending_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_inst_d  = enc_word;
                    out_err_d   = enc_err;
                    out_first_d = 1'b1;
                    if (enc_expand) begin
                        pending_d = addi_word;
                        state_d   = StExp2;
                    end
                end else if (consume) begin
                    out_valid_d = 1'b0;
                end
            end
            StExp2: begin
                if (consume) begin
                    out_inst_d  = pending_q;
                    out_err_d   = 1'b0;
                    out_first_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'h0;
            out_err_q   <= 1'b0;
            out_first_q <= 1'b0;
            pending_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_err_q   <= out_err_d;
            out_first_q <= out_first_d;
            pending_q   <= pending_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_err   = out_err_q;
    assign out_first = out_first_q;

endmodule
